// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch-queue widths, packet layout and default depth
package fetch_queue_pkg;
   localparam int FQ_DEPTH = 8;
   localparam int GHR_BUS = 5;
   localparam int ADDR_BUS = 32;
   localparam int INST_BUS = 32;
   localparam int FQ_ENTRY_WIDTH = 1 + GHR_BUS + ADDR_BUS + INST_BUS;
   localparam int FQ_SEG_INST = 0;
   localparam int FQ_SEG_PC = FQ_SEG_INST + INST_BUS;
   localparam int FQ_SEG_PHT = FQ_SEG_PC + ADDR_BUS;
   localparam int FQ_SEG_TAKEN = FQ_SEG_PHT + GHR_BUS;
endpackage

// File: rtl/fetch_queue_ptr_ctrl.sv
// fq_ptr_ctrl: head/tail/count bookkeeping with push/pop qualification and flush
module fq_ptr_ctrl
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_idx,
   output logic [AW-1:0] rd_idx,
   output logic [CW-1:0] count
);
   logic [AW-1:0] head, tail;
   logic push, pop;
   assign in_ready = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push = in_valid && in_ready && !flush;
   assign pop = out_valid && out_ready && !flush;
   assign wr_en = push;
   assign wr_idx = tail;
   assign rd_idx = head;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         head <= head + AW'(pop);
         tail <= tail + AW'(push);
         count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID packet FIFO with fall-through head and whole-queue flush
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int ADDR_WIDTH = ADDR_BUS,
   parameter int INST_WIDTH = INST_BUS,
   parameter int GHR_WIDTH = GHR_BUS,
   localparam int AW = $clog2(DEPTH),
   localparam int EW = 1 + GHR_WIDTH + ADDR_WIDTH + INST_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_is_branch_taken,
   input  logic [GHR_WIDTH-1:0]  in_pht_index,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [INST_WIDTH-1:0] in_inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_is_branch_taken,
   output logic [GHR_WIDTH-1:0]  out_pht_index,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [AW:0]           count
);
   logic [EW-1:0] mem [DEPTH];
   logic wr_en;
   logic [AW-1:0] wr_idx, rd_idx;
   fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .out_ready(out_ready),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .wr_en(wr_en),
      .wr_idx(wr_idx),
      .rd_idx(rd_idx),
      .count(count)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= {in_is_branch_taken, in_pht_index, in_pc, in_inst};
      end
   end
   assign {out_is_branch_taken, out_pht_index, out_pc, out_inst} = mem[rd_idx];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue
module tb_fetch_queue;
   typedef struct packed {
      logic        t;
      logic [4:0]  ph;
      logic [31:0] pc;
      logic [31:0] in;
   } pkt_t;
   logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic in_is_branch_taken = 0;
   logic [4:0] in_pht_index = '0;
   logic [31:0] in_pc = '0, in_inst = '0;
   logic in_ready, out_valid, out_is_branch_taken;
   logic [4:0] out_pht_index;
   logic [31:0] out_pc, out_inst;
   logic [3:0] count;
   pkt_t sb[$];
   int errors = 0, checks = 0;
   fetch_queue dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_is_branch_taken(in_is_branch_taken),
      .in_pht_index(in_pht_index),
      .in_pc(in_pc),
      .in_inst(in_inst),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_is_branch_taken(out_is_branch_taken),
      .out_pht_index(out_pht_index),
      .out_pc(out_pc),
      .out_inst(out_inst),
      .count(count)
   );
   always #5 clk = ~clk;
   function automatic pkt_t mk(input logic t, input logic [4:0] ph, input logic [31:0] pc, input logic [31:0] in);
      return {t, ph, pc, in};
   endfunction
   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // one clock: drive, check against the model, then advance the model across the edge
   task automatic cyc(input logic v, input pkt_t p, input logic ordy, input logic fl);
      logic pu, po;
      in_valid = v;
      {in_is_branch_taken, in_pht_index, in_pc, in_inst} = p;
      out_ready = ordy;
      flush = fl;
      #2;
      chk("count", 72'(count), 72'(sb.size()));
      chk("out_valid", 72'(out_valid), 72'(sb.size() != 0));
      chk("in_ready", 72'(in_ready), 72'(sb.size() != 8));
      if (sb.size() != 0)
         chk("head", 72'({out_is_branch_taken, out_pht_index, out_pc, out_inst}), 72'(sb[0]));
      pu = v && sb.size() != 8 && !fl;
      po = ordy && sb.size() != 0 && !fl;
      @(posedge clk);
      #1;
      if (fl) sb.delete();
      else begin
         if (po) sb.delete(0);
         if (pu) sb.push_back(p);
      end
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 72'(out_valid), 72'(0));
      chk("rst_ready", 72'(in_ready), 72'(1));
      chk("rst_count", 72'(count), 72'(0));
      chk("rst_pc", 72'(out_pc), 72'(0));
      chk("rst_inst", 72'(out_inst), 72'(0));
      rst = 1;
      cyc(1, mk(0, 5, 32'hBFC00000, 32'h24020001), 0, 0);
      repeat (3) cyc(0, '0, 0, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      for (int i = 0; i < 10; i++) cyc(1, mk(i[0], 5'(i), 32'h100 + 32'(4 * i), 32'(i)), 0, 0);
      repeat (9) cyc(0, '0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(1, mk(1, 5'(i + 3), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i)), 0, 0);
      cyc(1, mk(0, 1, 32'h300, 32'hB0), 1, 0);
      cyc(1, mk(1, 2, 32'h304, 32'hB1), 1, 0);
      cyc(0, '0, 0, 0);
      repeat (9) cyc(0, '0, 1, 0);
      for (int i = 0; i < 20; i++) cyc(1, mk(i[1], 5'(i), 32'h400 + 32'(4 * i), ~32'(i)), 1, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, mk(0, 5'(i), 32'h500 + 32'(4 * i), 32'(i)), 0, 0);
      cyc(1, mk(1, 9, 32'hDEAD0000, 32'h1), 1, 1);
      cyc(0, '0, 0, 0);
      cyc(1, mk(1, 7, 32'h600, 32'hCAFE), 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 1, 0);
      for (int i = 0; i < 6; i++) cyc(1, mk(1, 5'(i), 32'h700 + 32'(4 * i), 32'(i)), 0, 0);
      cyc(0, '0, 0, 0);
      #2;
      rst = 0;
      #1;
      chk("async_count", 72'(count), 72'(0));
      chk("async_valid", 72'(out_valid), 72'(0));
      chk("async_pc", 72'(out_pc), 72'(0));
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1;
      cyc(0, '0, 0, 0);
      cyc(1, mk(0, 3, 32'h800, 32'h77), 0, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
